mux_sel_arbiter: RTL and testbench
==================================

// Module: mux_sel_arbiter
// PURPOSE
//  Round-robin arbiter directly upstream of mux_4x1; drives its 2-bit select.
//  Four sources raise req[i]; the arbiter grants one at a time and holds sel on the winner
//  until it releases. The winner's data then passes through mux_4x1 to Y.
//  Also drives a one-hot gnt and busy flag for source-side handshaking.
// PARAMETERS
//  MAX_HOLD  default 8  max consecutive grant cycles before forced rotation (HOLD_TIMEOUT_EN only); >=1
// PORTS
//  clk   in   1  single clock, rising edge
//  rst   in   1  asynchronous, active-high reset
//  req   in   4  request per source; bit i = mux input i (0=a,1=b,2=c,3=d)
//  done  in   1  current grant holder finished; sampled only while busy=1
//  sel   out  2  select to mux_4x1 s; registered
//  gnt   out  4  one-hot grant, gnt[sel] when busy; registered
//  busy  out  1  a grant is active; registered
// BEHAVIOUR
//  Reset (async, immediate, also mid-grant): sel=2'b00, gnt=4'b0000, busy=0, ptr=2'd3, hold_cnt=0, state=IDLE.
//  ptr = index of last grant; search order is ptr+1, ptr+2, ptr+3, ptr (mod 4, wraps 3->0).
//  FSM states: IDLE, GRANT.
//  IDLE: busy=0, gnt=0, sel holds last value.
//    req!=0 at edge -> winner w = first set bit in search order; next: GRANT, sel=w, gnt=1<<w, busy=1, ptr=w.
//    Latency: req high in cycle N -> gnt/sel valid after edge N+1 (one cycle).
//  GRANT: release condition R = done | ~req[sel] | timeout.
//    R=0 -> hold sel/gnt; hold_cnt++.
//    R=1 -> search remaining requests (req with bit sel masked off if ~req[sel] or timeout);
//      found -> switch directly to new winner at the same edge (no IDLE bubble), hold_cnt=0.
//      none  -> IDLE, gnt=0, busy=0.
//    done=1 while only req[sel] still high -> same source re-granted (it is last in search order).
//    timeout with no other request -> same source re-granted, hold_cnt=0.
//  Simultaneous events: done and req drop in same cycle = single release;
//    multiple new reqs = lowest search-order position wins.
//  gnt always one-hot or zero; gnt!=0 iff busy=1; sel changes only on a grant edge.
//  hold_cnt width $clog2(MAX_HOLD+1); saturates, never wraps.
// CONFIGURATION
//  HOLD_TIMEOUT_EN defined: timeout = (hold_cnt == MAX_HOLD-1) & ~done; forces rotation
//    after MAX_HOLD cycles so no source can starve the others.
//  HOLD_TIMEOUT_EN undefined: timeout tied 0, no hold counter; grant held until done or req drop.
// TESTING
//  1 rst=1 then 0, req=0 for 5 cycles -> sel=00, gnt=0000, busy=0 throughout.
//  2 req=0001 -> one edge later sel=00, gnt=0001, busy=1; done pulse with req=0011 -> next edge sel=01, gnt=0010.
//  3 req=1111 held, done pulsed every 3rd cycle -> sel sequence 00,01,10,11,00 (wrap), no IDLE cycles between grants.
//  4 req=0100 only, done=1 -> sel stays 10, gnt=0100 re-granted; then req=0000 -> next edge busy=0, gnt=0000, sel holds 10.
//  5 HOLD_TIMEOUT_EN, MAX_HOLD=4, req=0011, done=0 -> sel 00 for 4 cycles, then 01 for 4, then 00;
//    without macro sel stays 00 indefinitely.
//  6 rst asserted mid-grant (gnt=1000) between edges -> outputs clear immediately to reset values;
//    after release with req=1111 first grant goes to sel=00.
//  All: check gnt one-hot/zero and gnt==(busy<<sel) every cycle; drive mux_4x1 with sel and check Y == selected input.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a downstream mux_4x1, with one-hot grant and busy.
// Optional macro HOLD_TIMEOUT_EN forces rotation after MAX_HOLD consecutive grant cycles.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     r_state;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;
  logic [3:0] r_gnt;
  logic       r_busy;

  logic       w_found;
  logic [1:0] w_win;
  logic       w_timeout;
  logic       w_release;

  // Search starts just past the last winner, so the current holder is always
  // the last candidate: it keeps the grant only when no one else is asking.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && req[r_ptr + 2'(k + 1)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + 2'(k + 1);
      end
    end
  end

`ifdef HOLD_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] r_hold;

  assign w_timeout = (r_hold == HW'(MAX_HOLD - 1)) & ~done;

  // Counts cycles the current grant has been held; cleared on every (re)grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (r_state == GRANT && !w_release) begin
      if (r_hold != HW'(MAX_HOLD))
        r_hold <= r_hold + 1'b1;
    end else begin
      r_hold <= '0;
    end
  end
`else
  // No hold counter in this build; MAX_HOLD >= 1 makes this a constant 0.
  assign w_timeout = (MAX_HOLD < 1);
`endif

  assign w_release = done | ~req[r_sel] | w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= 2'b00;
      r_gnt   <= 4'b0000;
      r_busy  <= 1'b0;
      r_ptr   <= 2'd3;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_sel   <= w_win;
            r_gnt   <= 4'b0001 << w_win;
            r_busy  <= 1'b1;
            r_ptr   <= w_win;
          end
        end
        GRANT: begin
          if (w_release) begin
            if (w_found) begin
              r_sel <= w_win;
              r_gnt <= 4'b0001 << w_win;
              r_ptr <= w_win;
            end else begin
              r_state <= IDLE;
              r_gnt   <= 4'b0000;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 4'b0000;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sel  = r_sel;
  assign gnt  = r_gnt;
  assign busy = r_busy;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Randomized and directed bench for mux_sel_arbiter against a cycle-level reference model.
module tb_mux_sel_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;

  logic [7:0] data [4];
  logic [7:0] y;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_sel, m_ptr, m_hold;
  bit m_busy;

  mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .done (done),
    .sel  (sel),
    .gnt  (gnt),
    .busy (busy)
  );

  // stand-in for the downstream mux_4x1
  assign y = data[sel];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_sel  = 0;
    m_ptr  = 3;
    m_hold = 0;
    m_busy = 0;
  endfunction

  function automatic void model_edge(input logic [3:0] r, input logic d);
    bit rel;
    int order[$];
    int w;
    if (m_busy) begin
      rel = d || !r[m_sel];
`ifdef HOLD_TIMEOUT_EN
      if (m_hold == MAX_HOLD - 1 && !d) rel = 1;
`endif
      if (!rel) begin
        if (m_hold < MAX_HOLD) m_hold++;
        return;
      end
    end else if (r == 4'b0000) begin
      return;
    end
    for (int k = 1; k <= 4; k++) order.push_back((m_ptr + k) % 4);
    w = -1;
    foreach (order[i]) if (w < 0 && r[order[i]]) w = order[i];
    m_hold = 0;
    if (w >= 0) begin
      m_sel  = w;
      m_ptr  = w;
      m_busy = 1;
    end else begin
      m_busy = 0;
    end
  endfunction

  task automatic check_outputs();
    check("sel", 32'(sel), 32'(m_sel));
    check("busy", 32'(busy), 32'(m_busy));
    check("gnt", 32'(gnt), m_busy ? (32'd1 << m_sel) : 32'd0);
    check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    check("mux_y", 32'(y), 32'(data[m_sel]));
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    for (int i = 0; i < 4; i++) data[i] = 8'($urandom_range(0, 255));
    #1;
    check_outputs();
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req  = 4'b0000;
    done = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    for (int i = 0; i < 4; i++) data[i] = 8'(i * 17 + 3);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();

    // idle with no requests
    repeat (5) step(4'b0000, 1'b0);

    // single request, then handoff on done
    step(4'b0001, 1'b0);
    check("t2_sel0", 32'(sel), 32'd0);
    check("t2_gnt0", 32'(gnt), 32'b0001);
    step(4'b0011, 1'b1);
    check("t2_sel1", 32'(sel), 32'd1);
    check("t2_gnt1", 32'(gnt), 32'b0010);

    // all requesting, done every third cycle: full rotation with wrap
    step(4'b0000, 1'b0);
    for (int i = 0; i < 15; i++) step(4'b1111, (i % 3) == 2);

    // lone requester re-granted on done, then release to idle
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    check("t4_regrant", 32'(gnt), 32'b0100);
    step(4'b0000, 1'b0);
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_idle_sel", 32'(sel), 32'd2);

    // hold timeout rotation (or indefinite hold without the macro)
    mid_reset();
    for (int i = 0; i < 12; i++) step(4'b0011, 1'b0);

    // reset mid-grant on source d, then fresh arbitration starts at source a
    mid_reset();
    step(4'b1000, 1'b0);
    check("t6_gnt3", 32'(gnt), 32'b1000);
    mid_reset();
    step(4'b1111, 1'b0);
    check("t6_first", 32'(sel), 32'd0);

    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      r = req;
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) mid_reset();
      else step(r, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
